dot_product_engine: RTL and testbench
=====================================

Name: dot_product_engine

Overview:
Parametrised successor to the single-row fixed-lane multiplier. Computes one signed dot product per start: ROW_LEN packed words from pixel memory against row `row_select` of weight memory, with LANES unsigned-pixel × signed-weight products per word. Handles synchronous one-cycle-latency RAMs and provides a valid/ready result handshake, an abort input, optional saturation and optional ReLU. Sits between the pixel/weight RAMs and the result writer in the classifier datapath.

Parameters:
LANES, 2, pixel/weight pairs per memory word
PIXEL_BITS, 8, unsigned pixel width per lane
WEIGHT_BITS, 16, signed weight width per lane
ROW_LEN, 392, words per row (≥2)
NUM_ROWS, 10, weight rows available
RESULT_BITS, 32, signed result width
ACC_BITS, 48, internal signed accumulator width (≥ RESULT_BITS+2, sized so no internal wrap)
PIX_ADDR_BITS, 10, pixel address width
WT_ADDR_BITS, 12, weight address width
PIXEL_ADDR_START, 0, pixel base address
WEIGHT_ADDR_START, 0, weight base address

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
row_select  in  $clog2(NUM_ROWS)  row index, latched on accepted start
sat_en  in  1  1=clamp result, 0=truncate; latched on start
relu_en  in  1  1=clamp negatives to 0; latched on start
abort  in  1  cancel current operation
pixel_data  in  LANES*PIXEL_BITS  RAM read data, lane 0 in LSBs
weight_data  in  LANES*WEIGHT_BITS  RAM read data, lane 0 in LSBs
pixel_address  out  PIX_ADDR_BITS  pixel RAM address
weight_address  out  WT_ADDR_BITS  weight RAM address
busy  out  1  high in FETCH/DRAIN
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result  out  RESULT_BITS  final value
overflow  out  1  accumulated sum out of signed RESULT_BITS range
bad_row  out  1  one-cycle pulse: start rejected, row_select ≥ NUM_ROWS

Behaviour:
- Reset: state IDLE; accumulator 0; index counter 0; busy=0, result_valid=0, result=0, overflow=0, bad_row=0; addresses at base values.
- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE: start=1 and row_select<NUM_ROWS → latch row/sat_en/relu_en, clear accumulator and index → FETCH. start=1 and row_select≥NUM_ROWS → bad_row=1 for one cycle, stay IDLE.
- FETCH: issue index k=0..ROW_LEN-1, one per cycle. pixel_address = PIXEL_ADDR_START+k; weight_address = WEIGHT_ADDR_START + row*ROW_LEN + k. After k=ROW_LEN-1 → DRAIN.
- Read data for index k is valid the cycle after issue. acc += Σ lanes ( zero-extended pixel × signed weight ), registered at end of that cycle. First FETCH cycle adds nothing.
- DRAIN: single cycle that accumulates the last word, then → HOLD. Addresses return to base in DRAIN/HOLD/IDLE.
- HOLD: result_valid=1; result/overflow stable until the cycle with result_ready=1, then → IDLE, result_valid=0. A new start is accepted only from IDLE, so at least one idle cycle separates results.
- Result: overflow = acc outside [-2^(RESULT_BITS-1), 2^(RESULT_BITS-1)-1]. If sat_en: clamp to min/max; else keep low RESULT_BITS. ReLU is applied after saturation/truncation: a negative value becomes 0. overflow reflects the raw sum and is independent of relu_en.
- Latency: start accept edge → result_valid high after ROW_LEN+2 cycles.
- abort (FETCH/DRAIN/HOLD) → IDLE on the next edge; result_valid drops; no result is delivered; accumulator cleared. abort takes priority over result_ready.
- start while not in IDLE is ignored. rst mid-operation returns all outputs to reset values immediately.

Test Plan:
Bench config LANES=2, ROW_LEN=4, NUM_ROWS=3, RESULT_BITS=16:
- pixels all 0xFF, weights all 0x7FFF, sat_en=1, row 0 → result=0x7FFF, overflow=1, valid exactly 6 cycles after start.
- Same stimulus, sat_en=0 → result=0xF808 (low 16 bits of 0x3FBF808), overflow=1.
- pixels 0x01, weights 0x8000 (-32768): relu_en=0, sat_en=1 → 0x8000 with overflow=1; relu_en=1 → 0x0000 with overflow=1.
- row_select=2 → weight_address sequence 8,9,10,11 and pixel_address sequence 0,1,2,3; row_select=3 → bad_row pulses once, busy stays 0.
- result_ready held low 10 cycles → result stable and valid held; ready pulse → IDLE next cycle; start during HOLD ignored.
- abort on the 2nd FETCH cycle → IDLE next cycle, no result_valid; an immediate restart with pixels=1 and weights=1 yields 8, with no residue from the aborted run.

Source files
------------

// File: rtl/dot_product_engine_if.sv
// Result handshake between the dot-product engine and the result writer.
// The engine drives the master side; the writer takes the slave side.
interface dot_product_engine_if #(
    parameter int RESULT_BITS = 32
);
    logic                   result_valid;
    logic                   result_ready;
    logic [RESULT_BITS-1:0] result;
    logic                   overflow;

    modport master (
        output result_valid,
        output result,
        output overflow,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result,
        input  overflow,
        output result_ready
    );
endinterface

// File: rtl/dot_product_engine.sv
// Signed dot product of one packed pixel row against a selected weight row.
// Streams ROW_LEN words from one-cycle-latency RAMs; result via handshake.
module dot_product_engine #(
    parameter int LANES             = 2,
    parameter int PIXEL_BITS        = 8,
    parameter int WEIGHT_BITS       = 16,
    parameter int ROW_LEN           = 392,
    parameter int NUM_ROWS          = 10,
    parameter int RESULT_BITS       = 32,
    parameter int ACC_BITS          = 48,
    parameter int PIX_ADDR_BITS     = 10,
    parameter int WT_ADDR_BITS      = 12,
    parameter int PIXEL_ADDR_START  = 0,
    parameter int WEIGHT_ADDR_START = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(NUM_ROWS)-1:0]  row_select,
    input  logic                         sat_en,
    input  logic                         relu_en,
    input  logic                         abort,
    input  logic [LANES*PIXEL_BITS-1:0]  pixel_data,
    input  logic [LANES*WEIGHT_BITS-1:0] weight_data,
    output logic [PIX_ADDR_BITS-1:0]     pixel_address,
    output logic [WT_ADDR_BITS-1:0]      weight_address,
    output logic                         busy,
    output logic                         bad_row,
    dot_product_engine_if.master         res
);
    localparam int RS_BITS   = $clog2(NUM_ROWS);
    localparam int IDX_BITS  = $clog2(ROW_LEN);
    localparam int PROD_BITS = PIXEL_BITS + WEIGHT_BITS + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [RS_BITS:0]  NROWS = (RS_BITS+1)'(NUM_ROWS);
    localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(ROW_LEN - 1);
    localparam logic [PIX_ADDR_BITS-1:0] PBASE =
        PIX_ADDR_BITS'(PIXEL_ADDR_START);
    localparam logic [WT_ADDR_BITS-1:0] WBASE =
        WT_ADDR_BITS'(WEIGHT_ADDR_START);
    localparam logic [WT_ADDR_BITS-1:0] WROW = WT_ADDR_BITS'(ROW_LEN);

    localparam logic signed [ACC_BITS-1:0] RMAX =
        {{(ACC_BITS-RESULT_BITS+1){1'b0}}, {(RESULT_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] RMIN =
        {{(ACC_BITS-RESULT_BITS+1){1'b1}}, {(RESULT_BITS-1){1'b0}}};

    logic [1:0]                  state;
    logic [IDX_BITS-1:0]         idx;
    logic [RS_BITS-1:0]          row_q;
    logic                        sat_q;
    logic                        relu_q;
    logic                        rd_vld;
    logic signed [ACC_BITS-1:0]  acc;
    logic [RESULT_BITS-1:0]      result_q;
    logic                        ovf_q;

    logic signed [PROD_BITS-1:0] prod [LANES];
    logic signed [ACC_BITS-1:0]  lane_sum;
    logic signed [ACC_BITS-1:0]  acc_nxt;
    logic                        ovf_nxt;
    logic [RESULT_BITS-1:0]      res_sat;
    logic [RESULT_BITS-1:0]      res_nxt;
    logic                        row_ok;

    // Pixels are unsigned: a zero MSB keeps them positive in the signed product.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign prod[l] =
            $signed({1'b0, pixel_data[l*PIXEL_BITS +: PIXEL_BITS]}) *
            $signed(weight_data[l*WEIGHT_BITS +: WEIGHT_BITS]);
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + ACC_BITS'(prod[l]);
        end
    end

    assign acc_nxt = acc + lane_sum;
    assign ovf_nxt = (acc_nxt > RMAX) || (acc_nxt < RMIN);

    always_comb begin
        res_sat = acc_nxt[RESULT_BITS-1:0];
        if (ovf_nxt && sat_q) begin
            res_sat = acc_nxt[ACC_BITS-1] ? RMIN[RESULT_BITS-1:0]
                                          : RMAX[RESULT_BITS-1:0];
        end
        res_nxt = (relu_q && res_sat[RESULT_BITS-1]) ? '0 : res_sat;
    end

    assign row_ok = {1'b0, row_select} < NROWS;

    assign pixel_address = (state == FETCH)
        ? PBASE + PIX_ADDR_BITS'(idx) : PBASE;
    assign weight_address = (state == FETCH)
        ? WBASE + WT_ADDR_BITS'(row_q) * WROW + WT_ADDR_BITS'(idx) : WBASE;

    assign busy             = (state == FETCH) || (state == DRAIN);
    assign res.result_valid = (state == HOLD);
    assign res.result       = result_q;
    assign res.overflow     = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            row_q    <= '0;
            sat_q    <= 1'b0;
            relu_q   <= 1'b0;
            rd_vld   <= 1'b0;
            acc      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            bad_row  <= 1'b0;
        end else begin
            bad_row <= 1'b0;
            if (abort && state != IDLE) begin
                state  <= IDLE;
                idx    <= '0;
                rd_vld <= 1'b0;
                acc    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && row_ok) begin
                            row_q  <= row_select;
                            sat_q  <= sat_en;
                            relu_q <= relu_en;
                            acc    <= '0;
                            idx    <= '0;
                            state  <= FETCH;
                        end else if (start) begin
                            bad_row <= 1'b1;
                        end
                    end
                    FETCH: begin
                        // Data issued last cycle arrives now.
                        if (rd_vld) acc <= acc_nxt;
                        rd_vld <= 1'b1;
                        if (idx == LAST) state <= DRAIN;
                        else idx <= idx + 1'b1;
                    end
                    DRAIN: begin
                        acc      <= acc_nxt;
                        result_q <= res_nxt;
                        ovf_q    <= ovf_nxt;
                        rd_vld   <= 1'b0;
                        idx      <= '0;
                        state    <= HOLD;
                    end
                    HOLD: begin
                        if (res.result_ready) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine with LANES=2, ROW_LEN=4, NUM_ROWS=3.
// Synchronous RAM models give one-cycle read latency.
module tb_dot_product_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  row_select = '0;
    logic        sat_en = 1'b0;
    logic        relu_en = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pixel_data = '0;
    logic [31:0] weight_data = '0;
    logic [9:0]  pixel_address;
    logic [11:0] weight_address;
    logic        busy;
    logic        bad_row;

    logic [15:0] pm [16];
    logic [31:0] wm [16];

    int checks = 0;
    int fails  = 0;

    dot_product_engine_if #(.RESULT_BITS(16)) rif ();

    dot_product_engine #(
        .LANES(2), .PIXEL_BITS(8), .WEIGHT_BITS(16), .ROW_LEN(4),
        .NUM_ROWS(3), .RESULT_BITS(16), .ACC_BITS(48),
        .PIX_ADDR_BITS(10), .WT_ADDR_BITS(12),
        .PIXEL_ADDR_START(0), .WEIGHT_ADDR_START(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .row_select(row_select),
        .sat_en(sat_en), .relu_en(relu_en), .abort(abort),
        .pixel_data(pixel_data), .weight_data(weight_data),
        .pixel_address(pixel_address), .weight_address(weight_address),
        .busy(busy), .bad_row(bad_row), .res(rif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pixel_data  <= pm[pixel_address[3:0]];
        weight_data <= wm[weight_address[3:0]];
    end

    task automatic fill(input logic [15:0] p, input logic [31:0] w);
        for (int i = 0; i < 16; i++) begin
            pm[i] = p;
            wm[i] = w;
        end
    endtask

    // Returns #1 after the edge that accepts start.
    task automatic do_start(input logic [1:0] row, input logic sat,
                            input logic relu);
        @(negedge clk);
        start = 1'b1;
        row_select = row;
        sat_en = sat;
        relu_en = relu;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accept edge (counted as 1) until valid.
    task automatic wait_valid(output int n);
        n = 1;
        while (!rif.result_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rif.result_ready = 1'b1;
        @(posedge clk);
        #1;
        rif.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rif.result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rif.result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl busy=%b valid=%b want 0 0",
                     busy, rif.result_valid);
        end
        checks++;
        if (rif.result !== 16'h0 || rif.overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_res result=%h ovf=%b want 0000 0",
                     rif.result, rif.overflow);
        end
        checks++;
        if (pixel_address !== 10'd0 || weight_address !== 12'd0
            || bad_row !== 1'b0) begin
            fails++;
            $display("FAIL reset_addr pa=%0d wa=%0d bad=%b want 0 0 0",
                     pixel_address, weight_address, bad_row);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturate();
        int n;
        fill(16'hFFFF, 32'h7FFF_7FFF);
        do_start(2'd0, 1'b1, 1'b0);
        wait_valid(n);
        checks++;
        if (n !== 6) begin
            fails++;
            $display("FAIL sat_latency cycles=%0d want 6", n);
        end
        checks++;
        if (rif.result !== 16'h7FFF || rif.overflow !== 1'b1) begin
            fails++;
            $display("FAIL sat_result result=%h ovf=%b want 7fff 1",
                     rif.result, rif.overflow);
        end
        consume();
    endtask

    task automatic test_truncate();
        int n;
        fill(16'hFFFF, 32'h7FFF_7FFF);
        do_start(2'd0, 1'b0, 1'b0);
        wait_valid(n);
        checks++;
        if (n !== 6 || rif.result !== 16'hF808 || rif.overflow !== 1'b1) begin
            fails++;
            $display("FAIL trunc_result n=%0d result=%h ovf=%b want 6 f808 1",
                     n, rif.result, rif.overflow);
        end
        consume();
    endtask

    task automatic test_relu();
        int n;
        fill(16'h0101, 32'h8000_8000);
        do_start(2'd0, 1'b1, 1'b0);
        wait_valid(n);
        checks++;
        if (rif.result !== 16'h8000 || rif.overflow !== 1'b1) begin
            fails++;
            $display("FAIL neg_sat result=%h ovf=%b want 8000 1",
                     rif.result, rif.overflow);
        end
        consume();
        do_start(2'd0, 1'b1, 1'b1);
        wait_valid(n);
        checks++;
        if (rif.result !== 16'h0000 || rif.overflow !== 1'b1) begin
            fails++;
            $display("FAIL relu result=%h ovf=%b want 0000 1",
                     rif.result, rif.overflow);
        end
        consume();
    endtask

    task automatic test_addressing();
        int n;
        // Pixel word k: lane0=k+1, lane1=1. Weight word a: lane0=a, lane1=16.
        for (int i = 0; i < 16; i++) begin
            pm[i] = {8'd1, 8'(i + 1)};
            wm[i] = {16'd16, 16'(i)};
        end
        do_start(2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pixel_address !== 10'(k) || weight_address !== 12'(8 + k)
                || busy !== 1'b1) begin
                fails++;
                $display("FAIL addr_k%0d pa=%0d wa=%0d busy=%b want %0d %0d 1",
                         k, pixel_address, weight_address, busy, k, 8 + k);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (pixel_address !== 10'd0 || weight_address !== 12'd0) begin
            fails++;
            $display("FAIL addr_drain pa=%0d wa=%0d want 0 0",
                     pixel_address, weight_address);
        end
        wait_valid(n);
        checks++;
        if (rif.result !== 16'h00A4 || rif.overflow !== 1'b0) begin
            fails++;
            $display("FAIL row2_result result=%h ovf=%b want 00a4 0",
                     rif.result, rif.overflow);
        end
        consume();
        do_start(2'd3, 1'b0, 1'b0);
        checks++;
        if (bad_row !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bad_row_pulse bad=%b busy=%b want 1 0",
                     bad_row, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bad_row !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bad_row_clear bad=%b busy=%b want 0 0",
                     bad_row, busy);
        end
    endtask

    task automatic test_hold();
        int n;
        fill(16'h0101, 32'h0001_0001);
        do_start(2'd1, 1'b0, 1'b0);
        wait_valid(n);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                @(negedge clk);
                start = 1'b1;
                row_select = 2'd0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            checks++;
            if (rif.result_valid !== 1'b1 || rif.result !== 16'd8
                || busy !== 1'b0) begin
                fails++;
                $display("FAIL hold_c%0d valid=%b result=%h busy=%b want 1 0008 0",
                         c, rif.result_valid, rif.result, busy);
            end
        end
        consume();
        checks++;
        if (rif.result_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_release valid=%b busy=%b want 0 0",
                     rif.result_valid, busy);
        end
    endtask

    task automatic test_abort();
        int n;
        fill(16'hFFFF, 32'h7FFF_7FFF);
        do_start(2'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rif.result_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle busy=%b valid=%b want 0 0",
                     busy, rif.result_valid);
        end
        fill(16'h0101, 32'h0001_0001);
        do_start(2'd0, 1'b0, 1'b0);
        wait_valid(n);
        checks++;
        if (n !== 6 || rif.result !== 16'd8 || rif.overflow !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart n=%0d result=%h ovf=%b want 6 0008 0",
                     n, rif.result, rif.overflow);
        end
        consume();
    endtask

    task automatic test_reset_midop();
        fill(16'h0101, 32'h0001_0001);
        do_start(2'd1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || weight_address !== 12'd0) begin
            fails++;
            $display("FAIL rst_midop busy=%b wa=%0d want 0 0",
                     busy, weight_address);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        fill(16'h0, 32'h0);
        rif.result_ready = 1'b0;
        test_reset();
        test_saturate();
        test_truncate();
        test_relu();
        test_addressing();
        test_hold();
        test_abort();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
